// File: rtl/btn_debounce_bank.sv
// ============================================================================
//  Module      : btn_debounce_bank
//  Description : Bank of push-button conditioners: 2-flop synchroniser,
//                counter debounce, press/release pulses, hold auto-repeat.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module btn_debounce_bank #(
    parameter int N_BTN         = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int DEBOUNCE_CYC  = 16,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] level
);

    localparam int c_DCW    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int c_RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RCW    = (c_RC_MAX > 1) ? $clog2(c_RC_MAX) : 1;

    localparam logic [c_DCW-1:0] c_DC_LAST     = c_DCW'(DEBOUNCE_CYC - 1);
    localparam logic [c_RCW-1:0] c_DELAY_LAST  = c_RCW'(REPEAT_DELAY - 1);
    localparam logic [c_RCW-1:0] c_PERIOD_LAST = c_RCW'(REPEAT_PERIOD - 1);
    localparam logic [N_BTN-1:0] c_INACTIVE    = {N_BTN{ACTIVE_LOW != 0}};

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_HOLD   = 2'd1;
    localparam logic [1:0] c_REPEAT = 2'd2;

    logic [N_BTN-1:0] r_s1;
    logic [N_BTN-1:0] r_s2;
    logic [N_BTN-1:0] w_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= c_INACTIVE;
            r_s2 <= c_INACTIVE;
        end else begin
            r_s1 <= btn;
            r_s2 <= r_s1;
        end
    end

    // XOR with the idle pin level yields 1 = pressed for either polarity
    assign w_act = r_s2 ^ c_INACTIVE;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic             r_lvl;
        logic [c_DCW-1:0] r_dc;
        logic [1:0]       r_state;
        logic [c_RCW-1:0] r_rc;
        logic             r_press;
        logic             r_rel;

        logic             w_lvl_next;
        logic [c_DCW-1:0] w_dc_next;
        logic             w_rise;
        logic             w_fall;
        logic [1:0]       w_state_next;
        logic [c_RCW-1:0] w_rc_next;
        logic             w_press_next;
        logic             w_rel_next;

        always_comb begin
            w_lvl_next = r_lvl;
            w_dc_next  = '0;
            if (w_act[i] != r_lvl) begin
                if (r_dc == c_DC_LAST) begin
                    w_lvl_next = w_act[i];
                end else begin
                    w_dc_next = r_dc + 1'b1;
                end
            end
        end

        assign w_rise = w_lvl_next & ~r_lvl;
        assign w_fall = ~w_lvl_next & r_lvl;

        // Pulses are registered alongside the level so they share its cycle
        always_comb begin
            w_state_next = r_state;
            w_rc_next    = r_rc;
            w_press_next = 1'b0;
            w_rel_next   = 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_rise) begin
                        w_press_next = 1'b1;
                        w_state_next = c_HOLD;
                        w_rc_next    = '0;
                    end
                end
                c_HOLD: begin
                    if (w_fall) begin
                        w_rel_next   = 1'b1;
                        w_state_next = c_IDLE;
                        w_rc_next    = '0;
                    end else if (REPEAT_EN != 0) begin
                        if (r_rc == c_DELAY_LAST) begin
                            w_press_next = 1'b1;
                            w_state_next = c_REPEAT;
                            w_rc_next    = '0;
                        end else begin
                            w_rc_next = r_rc + 1'b1;
                        end
                    end
                end
                c_REPEAT: begin
                    if (w_fall) begin
                        w_rel_next   = 1'b1;
                        w_state_next = c_IDLE;
                        w_rc_next    = '0;
                    end else if (r_rc == c_PERIOD_LAST) begin
                        w_press_next = 1'b1;
                        w_rc_next    = '0;
                    end else begin
                        w_rc_next = r_rc + 1'b1;
                    end
                end
                default: begin
                    w_state_next = c_IDLE;
                    w_rc_next    = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_lvl   <= 1'b0;
                r_dc    <= '0;
                r_state <= c_IDLE;
                r_rc    <= '0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
            end else begin
                r_lvl   <= w_lvl_next;
                r_dc    <= w_dc_next;
                r_state <= w_state_next;
                r_rc    <= w_rc_next;
                r_press <= w_press_next;
                r_rel   <= w_rel_next;
            end
        end

        assign press[i]         = r_press;
        assign release_pulse[i] = r_rel;
        assign level[i]         = r_lvl;
    end

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce_bank.sv
// ============================================================================
//  Module      : tb_btn_debounce_bank
//  Description : Randomised bench for btn_debounce_bank against a sample-
//                history reference model; two polarity/repeat configurations.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_btn_debounce_bank;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] p   = '0;
    logic [N-1:0] btn_a, btn_b;
    logic [N-1:0] press_a, rel_a, lvl_a;
    logic [N-1:0] press_b, rel_b, lvl_b;

    assign btn_a = ~p;
    assign btn_b = p;

    always #5 clk = ~clk;

    btn_debounce_bank #(
        .N_BTN(N), .ACTIVE_LOW(1), .DEBOUNCE_CYC(4),
        .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) u_dut_a (
        .clk(clk), .rst(rst), .btn(btn_a),
        .press(press_a), .release_pulse(rel_a), .level(lvl_a)
    );

    btn_debounce_bank #(
        .N_BTN(N), .ACTIVE_LOW(0), .DEBOUNCE_CYC(5),
        .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) u_dut_b (
        .clk(clk), .rst(rst), .btn(btn_b),
        .press(press_b), .release_pulse(rel_b), .level(lvl_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: sampled pressed history (index 0 = newest), level, time since rise
    bit           hist [2][N][16];
    bit           mlvl [2][N];
    int           mt   [2][N];
    logic [N-1:0] ep [2];
    logic [N-1:0] er [2];
    logic [N-1:0] el [2];

    int cnt_press_a [N];
    int cnt_rel_a   [N];
    int cnt_press_b [N];
    int cnt_rel_b   [N];
    int cnt_any, cnt_pair;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // Level flips once the synchronised value has sat at the opposite level for
    // deb consecutive edges; repeats fire at dly, dly+per, ... edges after the rise.
    task automatic model_edge(input int m, input int deb, input bit ren,
                              input int dly, input int per);
        bit flip;
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                for (int k = 0; k < 16; k++) hist[m][c][k] = 1'b0;
                mlvl[m][c] = 1'b0;
                mt[m][c]   = 0;
                ep[m][c]   = 1'b0;
                er[m][c]   = 1'b0;
            end else begin
                flip = 1'b1;
                for (int k = 1; k <= deb; k++)
                    if (hist[m][c][k] == mlvl[m][c]) flip = 1'b0;
                ep[m][c] = 1'b0;
                er[m][c] = 1'b0;
                if (flip) begin
                    mlvl[m][c] = ~mlvl[m][c];
                    if (mlvl[m][c]) begin
                        ep[m][c] = 1'b1;
                        mt[m][c] = 0;
                    end else begin
                        er[m][c] = 1'b1;
                    end
                end else if (mlvl[m][c]) begin
                    mt[m][c]++;
                    if (ren && (mt[m][c] == dly ||
                        (mt[m][c] > dly && (mt[m][c] - dly) % per == 0)))
                        ep[m][c] = 1'b1;
                end
                for (int k = 15; k > 0; k--) hist[m][c][k] = hist[m][c][k-1];
                hist[m][c][0] = p[c];
            end
            el[m][c] = mlvl[m][c];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0, 4, 1'b1, 10, 3);
        model_edge(1, 5, 1'b0, 10, 3);
        #1;
        chk("A_press",   press_a, ep[0]);
        chk("A_release", rel_a,   er[0]);
        chk("A_level",   lvl_a,   el[0]);
        chk("B_press",   press_b, ep[1]);
        chk("B_release", rel_b,   er[1]);
        chk("B_level",   lvl_b,   el[1]);
        for (int c = 0; c < N; c++) begin
            cnt_press_a[c] += int'(press_a[c]);
            cnt_rel_a[c]   += int'(rel_a[c]);
            cnt_press_b[c] += int'(press_b[c]);
            cnt_rel_b[c]   += int'(rel_b[c]);
        end
        if (press_a != '0)      cnt_any++;
        if (press_a == 4'b1001) cnt_pair++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clr_cnt();
        for (int c = 0; c < N; c++) begin
            cnt_press_a[c] = 0;
            cnt_rel_a[c]   = 0;
            cnt_press_b[c] = 0;
            cnt_rel_b[c]   = 0;
        end
        cnt_any  = 0;
        cnt_pair = 0;
    endtask

    initial begin
        int dur;
        clr_cnt();

        // Reset with every button held, then held through reset release
        p   = '1;
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(20);
        p = '0;
        run(20);

        // Clean press on ch0, 50 cycles
        clr_cnt();
        p[0] = 1'b1;
        run(50);
        p[0] = 1'b0;
        run(20);
        chk("B0_press_cnt", cnt_press_b[0], 1);
        chk("B0_rel_cnt",   cnt_rel_b[0],   1);
        chk("A0_press_cnt", cnt_press_a[0], 15);
        chk("A0_rel_cnt",   cnt_rel_a[0],   1);

        // Bounce on ch1: toggle every 2 cycles
        clr_cnt();
        for (int i = 0; i < 10; i++) begin
            p[1] = ~p[1];
            run(2);
        end
        run(10);
        chk("A1_bounce_press", cnt_press_a[1], 0);
        chk("A1_bounce_rel",   cnt_rel_a[1],   0);
        chk("B1_bounce_press", cnt_press_b[1], 0);
        clr_cnt();
        p[1] = 1'b1;
        run(10);
        p[1] = 1'b0;
        run(20);
        chk("A1_stable_press", cnt_press_a[1], 1);
        chk("B1_stable_press", cnt_press_b[1], 1);

        // Auto-repeat on ch2
        clr_cnt();
        p[2] = 1'b1;
        run(36);
        p[2] = 1'b0;
        run(20);
        chk("A2_repeat_cnt", cnt_press_a[2], 10);
        chk("A2_rel_cnt",    cnt_rel_a[2],   1);
        chk("B2_press_cnt",  cnt_press_b[2], 1);

        // Simultaneous ch0 + ch3
        clr_cnt();
        p = 4'b1001;
        run(10);
        p = '0;
        run(20);
        chk("A_pair_any",  cnt_any,  1);
        chk("A_pair_both", cnt_pair, 1);

        // Reset mid-hold
        p = '1;
        run(15);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(20);
        p = '0;
        run(20);

        // Random activity: short bounces, long holds, occasional reset
        for (int i = 0; i < 400; i++) begin
            p = p ^ 4'($urandom);
            dur = (($urandom % 8) == 0) ? int'($urandom_range(20, 60))
                                        : int'($urandom_range(1, 8));
            run(dur);
            if (($urandom % 50) == 0) begin
                rst = 1'b1;
                run(1);
                rst = 1'b0;
            end
        end
        p = '0;
        run(30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
